battle_sequencer: RTL and testbench



---
 rtl/battle_pkg.sv | 55 +++++
 rtl/battle_sequencer_phase_watchdog.sv | 41 ++++
 rtl/battle_sequencer.sv | 150 +++++++++++++++
 tb/tb_battle_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared state codes, phase indices and helpers for the battle turn sequencer.
package battle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned TURN_W  = 4;
  localparam int unsigned PHASE_W = 2;

  localparam logic [STATE_W-1:0] CODE_IDLE      = 4'b0000;
  localparam logic [STATE_W-1:0] CODE_MENU      = 4'b0001;
  localparam logic [STATE_W-1:0] CODE_DIALOG    = 4'b0010;
  localparam logic [STATE_W-1:0] CODE_ATTACK    = 4'b1000;
  localparam logic [STATE_W-1:0] CODE_GAME_OVER = 4'b0100;
  localparam logic [STATE_W-1:0] CODE_WIN       = 4'b1111;

  localparam logic [PHASE_W-1:0] PH_MENU   = 2'd0;
  localparam logic [PHASE_W-1:0] PH_DIALOG = 2'd1;
  localparam logic [PHASE_W-1:0] PH_ENEMY  = 2'd2;
  localparam logic [PHASE_W-1:0] PH_NONE   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = CODE_IDLE,
    S_MENU      = CODE_MENU,
    S_DIALOG    = CODE_DIALOG,
    S_ATTACK    = CODE_ATTACK,
    S_GAME_OVER = CODE_GAME_OVER,
    S_WIN       = CODE_WIN
  } state_t;

  // Which phase block a state addresses; PH_NONE for the non-phase states.
  function automatic logic [PHASE_W-1:0] state_to_phase(input state_t s);
    logic [PHASE_W-1:0] ph;
    ph = PH_NONE;
    case (s)
      S_MENU:   ph = PH_MENU;
      S_DIALOG: ph = PH_DIALOG;
      S_ATTACK: ph = PH_ENEMY;
      default:  ph = PH_NONE;
    endcase
    return ph;
  endfunction

  // Select one per-phase bit; PH_NONE reads as 0.
  function automatic logic phase_bit(input logic [2:0] v, input logic [PHASE_W-1:0] ph);
    logic b;
    b = 1'b0;
    case (ph)
      PH_MENU:   b = v[0];
      PH_DIALOG: b = v[1];
      PH_ENEMY:  b = v[2];
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/battle_sequencer_phase_watchdog.sv
// Per-phase acknowledge watchdog: counts frames since phase entry until the block shows busy.
module phase_watchdog #(
  parameter int unsigned ACK_TIMEOUT_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_start,
  input  logic new_frame,
  input  logic busy,
  output logic expired
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] count;
  logic             armed;
  logic [CNT_W-1:0] eff_count;
  logic             eff_armed;

  // The phase_start cycle already belongs to the new phase, so it sees a fresh counter.
  always_comb begin
    eff_count = phase_start ? '0 : count;
    eff_armed = phase_start ? 1'b1 : armed;
    expired   = eff_armed && !busy && new_frame &&
                (eff_count == CNT_W'(ACK_TIMEOUT_FRAMES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      armed <= 1'b1;
    end else begin
      armed <= eff_armed && !busy;
      if (new_frame && (eff_count != {CNT_W{1'b1}}))
        count <= eff_count + CNT_W'(1);
      else
        count <= eff_count;
    end
  end

endmodule

// File: rtl/battle_sequencer.sv
// Battle turn controller: frame-aligned phase sequencing with win/lose and ack timeouts.
// Optional SKIP_PHASE_EN adds skip_in, which completes the current phase like finished_in.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int unsigned NUM_TURNS          = 8,
  parameter int unsigned ACK_TIMEOUT_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
`ifdef SKIP_PHASE_EN
  input  logic       skip_in,
`endif
  input  logic       new_frame_in,
  input  logic [2:0] busy_in,
  input  logic [2:0] finished_in,
  input  logic       player_dead_in,
  input  logic       enemy_dead_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic       phase_start_out,
  output logic       timeout_err_out,
  output logic       game_over_out,
  output logic       win_out
);

  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_TURNS - 1);

  state_t            state, state_n;
  logic [TURN_W-1:0] turn, turn_n;
  logic              start_p, fin_p, pdead_p, edead_p;
  logic              start_pn, fin_pn, pdead_pn, edead_pn;
  logic              timeout_n;
  logic              trans;

  logic [PHASE_W-1:0] phase;
  logic               active;
  logic               skip_evt;
  logic               fin_evt, start_evt, pdead_evt, edead_evt;
  logic               wd_busy, wd_expired;

  assign phase  = state_to_phase(state);
  assign active = (phase != PH_NONE);

`ifdef SKIP_PHASE_EN
  assign skip_evt = skip_in;
`else
  assign skip_evt = 1'b0;
`endif

  // Same-cycle events join the pending flags so a pulse on the frame cycle counts.
  assign start_evt = start_p | start_in;
  assign fin_evt   = fin_p | (active & (phase_bit(finished_in, phase) | skip_evt));
  assign pdead_evt = pdead_p | player_dead_in;
  assign edead_evt = edead_p | enemy_dead_in;
  assign wd_busy   = active & phase_bit(busy_in, phase);

  phase_watchdog #(
    .ACK_TIMEOUT_FRAMES (ACK_TIMEOUT_FRAMES)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .phase_start (phase_start_out),
    .new_frame   (new_frame_in),
    .busy        (wd_busy),
    .expired     (wd_expired)
  );

  // Next phase, turn and pending-flag bookkeeping.
  always_comb begin
    state_n   = state;
    turn_n    = turn;
    trans     = 1'b0;
    start_pn  = start_evt;
    fin_pn    = fin_evt;
    pdead_pn  = pdead_evt;
    edead_pn  = edead_evt;
    timeout_n = timeout_err_out | (active & wd_expired);

    if (new_frame_in) begin
      case (state)
        S_MENU, S_DIALOG, S_ATTACK: begin
          if (pdead_evt) begin
            state_n = S_GAME_OVER;
          end else if (edead_evt) begin
            state_n = S_WIN;
          end else if (fin_evt || wd_expired) begin
            case (state)
              S_MENU:   state_n = S_DIALOG;
              S_DIALOG: state_n = S_ATTACK;
              default: begin
                if (turn == LAST_TURN) begin
                  state_n = S_WIN;
                end else begin
                  state_n = S_MENU;
                  turn_n  = turn + TURN_W'(1);
                end
              end
            endcase
          end
        end
        default: begin
          if (start_evt) begin
            state_n  = S_MENU;
            turn_n   = '0;
            pdead_pn = 1'b0;
            edead_pn = 1'b0;
          end
        end
      endcase
    end

    trans = (state_n != state);
    if (trans) begin
      start_pn = 1'b0;
      fin_pn   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      turn            <= '0;
      phase_start_out <= 1'b0;
      timeout_err_out <= 1'b0;
      game_over_out   <= 1'b0;
      win_out         <= 1'b0;
      start_p         <= 1'b0;
      fin_p           <= 1'b0;
      pdead_p         <= 1'b0;
      edead_p         <= 1'b0;
    end else begin
      state           <= state_n;
      turn            <= turn_n;
      phase_start_out <= trans;
      timeout_err_out <= timeout_n;
      game_over_out   <= (state_n == S_GAME_OVER);
      win_out         <= (state_n == S_WIN);
      start_p         <= start_pn;
      fin_p           <= fin_pn;
      pdead_p         <= pdead_pn;
      edead_p         <= edead_pn;
    end
  end

  assign state_out = state;
  assign turn_out  = turn;

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: per-cycle reference model plus directed literal checks.
module tb_battle_sequencer;

  localparam int NT  = 2;
  localparam int ACK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_in;
  logic       skip_in;
  logic       new_frame_in;
  logic [2:0] busy_in;
  logic [2:0] finished_in;
  logic       player_dead_in;
  logic       enemy_dead_in;
  logic [3:0] state_out;
  logic [3:0] turn_out;
  logic       phase_start_out;
  logic       timeout_err_out;
  logic       game_over_out;
  logic       win_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  battle_sequencer #(.NUM_TURNS(NT), .ACK_TIMEOUT_FRAMES(ACK)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_in        (start_in),
`ifdef SKIP_PHASE_EN
    .skip_in         (skip_in),
`endif
    .new_frame_in    (new_frame_in),
    .busy_in         (busy_in),
    .finished_in     (finished_in),
    .player_dead_in  (player_dead_in),
    .enemy_dead_in   (enemy_dead_in),
    .state_out       (state_out),
    .turn_out        (turn_out),
    .phase_start_out (phase_start_out),
    .timeout_err_out (timeout_err_out),
    .game_over_out   (game_over_out),
    .win_out         (win_out)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 menu, 2 dialog, 3 attack, 4 game over, 5 win.
  int m_ph, m_turn, m_frames;
  bit m_ps, m_terr, m_start, m_fin, m_pd, m_ed, m_seen, m_valid, chk_en;

  function automatic int code_of(input int ph);
    case (ph)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b1000;
      4: return 4'b0100;
      5: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    int idx, nxt, frames;
    bit inph, e_start, e_fin, e_pd, e_ed, seen, tmo, skp;
    if (rst) begin
      m_ph = 0; m_turn = 0; m_ps = 0; m_terr = 0;
      m_start = 0; m_fin = 0; m_pd = 0; m_ed = 0;
      m_frames = 0; m_seen = 0; m_valid = 1;
    end else begin
      inph = (m_ph >= 1 && m_ph <= 3);
      idx  = inph ? m_ph - 1 : 0;
`ifdef SKIP_PHASE_EN
      skp = skip_in;
`else
      skp = 1'b0;
`endif
      e_start = m_start | start_in;
      e_fin   = m_fin | (inph && (finished_in[idx] || skp));
      e_pd    = m_pd | player_dead_in;
      e_ed    = m_ed | enemy_dead_in;
      seen    = m_seen | (inph && busy_in[idx]);
      frames  = m_frames + (new_frame_in ? 1 : 0);
      tmo     = inph && new_frame_in && !seen && (frames == ACK);
      if (tmo) m_terr = 1;
      nxt = m_ph;
      if (new_frame_in) begin
        if (inph) begin
          if (e_pd) nxt = 4;
          else if (e_ed) nxt = 5;
          else if (e_fin || tmo) begin
            if (m_ph == 3) begin
              if (m_turn == NT - 1) nxt = 5;
              else begin nxt = 1; m_turn = m_turn + 1; end
            end else nxt = m_ph + 1;
          end
        end else if (e_start) begin
          nxt = 1; m_turn = 0; e_pd = 0; e_ed = 0;
        end
      end
      m_ps = (nxt != m_ph);
      if (m_ps) begin
        m_start = 0; m_fin = 0; m_frames = 0; m_seen = 0;
      end else begin
        m_start = e_start; m_fin = e_fin; m_frames = frames; m_seen = seen;
      end
      m_pd = e_pd; m_ed = e_ed; m_ph = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en && m_valid) begin
      chk("state", int'(state_out), code_of(m_ph));
      chk("turn", int'(turn_out), m_turn);
      chk("phase_start", int'(phase_start_out), int'(m_ps));
      chk("timeout_err", int'(timeout_err_out), int'(m_terr));
      chk("game_over", int'(game_over_out), (m_ph == 4) ? 1 : 0);
      chk("win", int'(win_out), (m_ph == 5) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    new_frame_in = 1'b1;
    step();
    new_frame_in = 1'b0;
    step();
    step();
  endtask

  task automatic fin(input logic [2:0] b);
    finished_in = b;
    step();
    finished_in = 3'b000;
  endtask

  task automatic start();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_in = 0; skip_in = 0; new_frame_in = 0;
    busy_in = 0; finished_in = 0; player_dead_in = 0; enemy_dead_in = 0;
    chk_en = 0;
    step(); step(); step();
    chk("rst_state", int'(state_out), 0);
    chk("rst_turn", int'(turn_out), 0);
    chk("rst_err", int'(timeout_err_out), 0);
    chk("rst_ps", int'(phase_start_out), 0);
    chk_en = 1;
    rst = 1'b0;
    step();

    // Start, first frame enters MENU with a single phase_start pulse
    start();
    new_frame_in = 1'b1;
    step();
    new_frame_in = 1'b0;
    chk("first_menu", int'(state_out), 4'b0001);
    chk("first_ps", int'(phase_start_out), 1);
    step();
    chk("ps_one_cycle", int'(phase_start_out), 0);

    // Full loop of two turns to WIN
    for (int t = 0; t < NT; t++) begin
      busy_in = 3'b001; fin(3'b001); frame();
      chk("to_dialog", int'(state_out), 4'b0010);
      busy_in = 3'b010; fin(3'b010); frame();
      chk("to_attack", int'(state_out), 4'b1000);
      busy_in = 3'b100; fin(3'b100); frame();
      if (t == 0) begin
        chk("turn1_menu", int'(state_out), 4'b0001);
        chk("turn1", int'(turn_out), 1);
      end
    end
    chk("win_state", int'(state_out), 4'b1111);
    chk("win_flag", int'(win_out), 1);
    chk("win_turn", int'(turn_out), 1);

    // Player death beats a same-cycle finish in ATTACK
    busy_in = 3'b000; start(); frame();
    busy_in = 3'b001; fin(3'b001); frame();
    busy_in = 3'b010; fin(3'b010); frame();
    busy_in = 3'b100;
    player_dead_in = 1'b1;
    fin(3'b100);
    frame();
    chk("dead_state", int'(state_out), 4'b0100);
    chk("dead_go", int'(game_over_out), 1);
    chk("dead_turn", int'(turn_out), 0);
    player_dead_in = 1'b0;

    // DIALOG never acknowledges: forced on the 4th frame, error sticks
    busy_in = 3'b000; start(); frame();
    busy_in = 3'b001; fin(3'b001); frame();
    busy_in = 3'b000;
    frame(); frame(); frame();
    chk("tmo_wait_state", int'(state_out), 4'b0010);
    chk("tmo_wait_err", int'(timeout_err_out), 0);
    frame();
    chk("tmo_state", int'(state_out), 4'b1000);
    chk("tmo_err", int'(timeout_err_out), 1);
    enemy_dead_in = 1'b1; step(); enemy_dead_in = 1'b0;
    frame();
    chk("edead_win", int'(state_out), 4'b1111);
    start(); frame();
    chk("restart_menu", int'(state_out), 4'b0001);
    chk("restart_err", int'(timeout_err_out), 1);

    // Finish for a non-current phase is ignored
    busy_in = 3'b001;
    fin(3'b100);
    frame(); frame(); frame();
    chk("ignore_fin", int'(state_out), 4'b0001);

`ifdef SKIP_PHASE_EN
    fin(3'b001); frame();
    skip_in = 1'b1; step(); skip_in = 1'b0;
    frame();
    chk("skip_dialog", int'(state_out), 4'b1000);
`endif

    // Reset mid-phase aborts and clears the sticky error
    rst = 1'b1; step();
    chk("mid_rst_state", int'(state_out), 0);
    chk("mid_rst_err", int'(timeout_err_out), 0);
    rst = 1'b0; step();

`ifdef SKIP_PHASE_EN
    skip_in = 1'b1; step(); skip_in = 1'b0;
    frame();
    chk("skip_idle", int'(state_out), 0);
`endif

    step();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
